// File: rtl/muldiv_if.sv
// Handshake and data bundle between the EX stage and the iterative
// multiply/divide unit.
interface muldiv_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic             mthi;
  logic             mtlo;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, flush,
    output mthi, mtlo, wdata,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, a, b, flush,
    input  mthi, mtlo, wdata,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit holding the HI/LO registers.
// One shift-add or restoring shift-subtract step per cycle.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input logic     clk,
  input logic     rst_n,
  muldiv_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam int W2 = 2 * WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [W2-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             div_q, div_d;
  logic             neg_q, neg_d;
  logic             rneg_q, rneg_d;
  logic             dz_q, dz_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             sa, sb, qbit;
  logic [WIDTH-1:0] ma, mb, quo, rem;
  logic [WIDTH:0]   msum, rsh;
  logic [WIDTH+1:0] diff;
  logic [W2-1:0]    prod;

  always_comb begin
    sa   = ~bus.op[0] & bus.a[WIDTH-1];
    sb   = ~bus.op[0] & bus.b[WIDTH-1];
    ma   = sa ? -bus.a : bus.a;
    mb   = sb ? -bus.b : bus.b;
    msum = {1'b0, acc_q[W2-1:WIDTH]}
         + {1'b0, (acc_q[0] ? opnd_q : '0)};
    rsh  = acc_q[W2-1:WIDTH-1];
    diff = {1'b0, rsh} - {2'b00, opnd_q};
    // diff < divisor whenever it is non-negative and divisor != 0
    qbit = ~|diff[WIDTH+1:WIDTH];
    prod = neg_q ? -acc_q : acc_q;
    quo  = acc_q[WIDTH-1:0];
    rem  = acc_q[W2-1:WIDTH];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    div_d   = div_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    dz_d    = dz_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = CALC;
          cnt_d   = '0;
          div_d   = bus.op[1];
          neg_d   = sa ^ sb;
          rneg_d  = sa;
          dz_d    = (bus.b == '0);
          opnd_d  = bus.op[1] ? mb : ma;
          acc_d   = {{WIDTH{1'b0}},
                     (bus.op[1] ? ma : mb)};
        end else begin
          if (bus.mthi) hi_d = bus.wdata;
          if (bus.mtlo) lo_d = bus.wdata;
        end
      end
      CALC: begin
        cnt_d = cnt_q + 1'b1;
        if (div_q) begin
          acc_d = qbit
            ? {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1}
            : {rsh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end else begin
          acc_d = {msum, acc_q[WIDTH-1:1]};
        end
        if (cnt_q == CW'(WIDTH - 1)) state_d = FIX;
      end
      FIX: begin
        state_d = IDLE;
        done_d  = 1'b1;
        if (div_q) begin
          lo_d = dz_q ? '1 : (neg_q ? -quo : quo);
          hi_d = rneg_q ? -rem : rem;
        end else begin
          {hi_d, lo_d} = prod;
        end
      end
      default: state_d = IDLE;
    endcase
    if (bus.flush && state_q != IDLE) begin
      state_d = IDLE;
      done_d  = 1'b0;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      opnd_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      div_q   <= 1'b0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      div_q   <= div_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: vector table, random ops
// against an arithmetic model, and control-path corner sequences.
module tb_muldiv_unit;
  localparam int W = 32;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;

  muldiv_if #(.WIDTH(W)) bus ();

  muldiv_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      nm;
    logic [1:0] op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  function automatic void model(input logic [1:0] op,
                                input logic [31:0] a,
                                input logic [31:0] b,
                                output logic [31:0] eh,
                                output logic [31:0] el);
    longint      sa;
    longint      sb;
    logic [63:0] p;
    logic [63:0] q;
    logic [63:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    p  = '0;
    q  = '0;
    r  = '0;
    case (op)
      2'd0: p = sa * sb;
      2'd1: p = {32'd0, a} * {32'd0, b};
      2'd2: if (b != 0) begin q = sa / sb; r = sa % sb; end
      default: if (b != 0) begin q = {32'd0, a / b}; r = {32'd0, a % b}; end
    endcase
    if (!op[1]) begin
      eh = p[63:32];
      el = p[31:0];
    end else if (b == 0) begin
      eh = a;
      el = '1;
    end else begin
      eh = r[31:0];
      el = q[31:0];
    end
  endfunction

  task automatic launch(input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b);
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    bus.start = 1'b1;
  endtask

  task automatic wait_done(output int lat, output int bcnt);
    lat  = -1;
    bcnt = 0;
    for (int n = 1; n <= 100; n++) begin
      @(negedge clk);
      bus.start = 1'b0;
      bus.flush = 1'b0;
      bus.mthi  = 1'b0;
      bus.mtlo  = 1'b0;
      if (bus.busy) bcnt++;
      if (bus.done) begin
        lat = n - 1;
        break;
      end
    end
  endtask

  task automatic do_op(input string nm, input logic [1:0] op,
                       input logic [31:0] a, input logic [31:0] b);
    logic [31:0] eh, el;
    int lat, bc;
    model(op, a, b, eh, el);
    launch(op, a, b);
    wait_done(lat, bc);
    chk({nm, " latency"}, 64'(lat), 64'd33);
    chk({nm, " busy"}, 64'(bc), 64'd33);
    chk({nm, " hi"}, 64'(bus.hi), 64'(eh));
    chk({nm, " lo"}, 64'(bus.lo), 64'(el));
  endtask

  initial begin
    vec_t vt[6];
    logic [31:0] eh, el, ph, pl;
    logic [1:0]  rop;
    logic [31:0] ra, rb;
    int lat, cnt, bc;

    n_chk  = 0;
    n_fail = 0;
    vt[0] = '{"mult_neg", 2'd0, 32'hFFFFFFFF, 32'h2,
              32'hFFFFFFFF, 32'hFFFFFFFE};
    vt[1] = '{"multu", 2'd1, 32'hFFFFFFFF, 32'h2,
              32'h1, 32'hFFFFFFFE};
    vt[2] = '{"div_neg", 2'd2, 32'hFFFFFFF9, 32'h2,
              32'hFFFFFFFF, 32'hFFFFFFFD};
    vt[3] = '{"divu", 2'd3, 32'h7, 32'h2, 32'h1, 32'h3};
    vt[4] = '{"divu_by0", 2'd3, 32'h7, 32'h0,
              32'h7, 32'hFFFFFFFF};
    vt[5] = '{"div_ovf", 2'd2, 32'h80000000, 32'hFFFFFFFF,
              32'h0, 32'h80000000};

    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.op    = 2'd0;
    bus.a     = '0;
    bus.b     = '0;
    bus.flush = 1'b0;
    bus.mthi  = 1'b0;
    bus.mtlo  = 1'b0;
    bus.wdata = '0;
    repeat (2) @(negedge clk);
    chk("reset busy", 64'(bus.busy), 64'd0);
    chk("reset done", 64'(bus.done), 64'd0);
    chk("reset hi", 64'(bus.hi), 64'd0);
    chk("reset lo", 64'(bus.lo), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle busy", 64'(bus.busy), 64'd0);

    for (int i = 0; i < 6; i++) begin
      int l2, b2;
      launch(vt[i].op, vt[i].a, vt[i].b);
      wait_done(l2, b2);
      chk({vt[i].nm, " latency"}, 64'(l2), 64'd33);
      chk({vt[i].nm, " busy"}, 64'(b2), 64'd33);
      chk({vt[i].nm, " hi"}, 64'(bus.hi), 64'(vt[i].hi));
      chk({vt[i].nm, " lo"}, 64'(bus.lo), 64'(vt[i].lo));
    end

    for (int i = 0; i < 40; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      case ($urandom_range(0, 4))
        0: rb = '0;
        1: rb = 32'($urandom_range(1, 15));
        2: rb = -32'($urandom_range(1, 15));
        default: rb = $urandom;
      endcase
      if (i == 7) begin
        rop = 2'd2;
        ra  = 32'h80000000;
        rb  = 32'hFFFFFFFF;
      end
      do_op($sformatf("rnd%0d", i), rop, ra, rb);
    end

    @(negedge clk);
    bus.mthi  = 1'b1;
    bus.wdata = 32'h12345678;
    @(negedge clk);
    chk("mthi hi", 64'(bus.hi), 64'h12345678);
    bus.mthi  = 1'b0;
    bus.mtlo  = 1'b1;
    bus.wdata = 32'h9ABCDEF0;
    @(negedge clk);
    bus.mtlo = 1'b0;
    chk("mtlo lo", 64'(bus.lo), 64'h9ABCDEF0);
    chk("mtlo hi kept", 64'(bus.hi), 64'h12345678);
    bus.mthi  = 1'b1;
    bus.mtlo  = 1'b1;
    bus.wdata = 32'hA5A5A5A5;
    @(negedge clk);
    bus.mthi = 1'b0;
    bus.mtlo = 1'b0;
    chk("both hi", 64'(bus.hi), 64'hA5A5A5A5);
    chk("both lo", 64'(bus.lo), 64'hA5A5A5A5);

    launch(2'd1, 32'd3, 32'd5);
    bus.mthi  = 1'b1;
    bus.wdata = 32'hFFFF0000;
    @(negedge clk);
    bus.start = 1'b0;
    bus.mthi  = 1'b0;
    chk("start wins hi", 64'(bus.hi), 64'hA5A5A5A5);
    chk("start wins busy", 64'(bus.busy), 64'd1);
    wait_done(lat, bc);
    chk("3x5 hi", 64'(bus.hi), 64'd0);
    chk("3x5 lo", 64'(bus.lo), 64'd15);

    model(2'd1, 32'hDEADBEEF, 32'h1234, eh, el);
    launch(2'd1, 32'hDEADBEEF, 32'h1234);
    lat = -1;
    for (int n = 1; n <= 100; n++) begin
      @(negedge clk);
      if (n == 1) bus.start = 1'b0;
      if (n == 5) begin
        launch(2'd2, 32'd7, 32'd0);
        bus.mthi  = 1'b1;
        bus.wdata = 32'hDEAD0000;
      end
      if (n == 6) begin
        bus.start = 1'b0;
        bus.mthi  = 1'b0;
      end
      if (n == 20) chk("hold lo", 64'(bus.lo), 64'd15);
      if (bus.done) begin
        lat = n - 1;
        break;
      end
    end
    chk("busy ign latency", 64'(lat), 64'd33);
    chk("busy ign hi", 64'(bus.hi), 64'(eh));
    chk("busy ign lo", 64'(bus.lo), 64'(el));
    cnt = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.busy) cnt++;
    end
    chk("no queued op", 64'(cnt), 64'd0);

    ph = bus.hi;
    pl = bus.lo;
    launch(2'd2, 32'h1000, 32'd3);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    chk("flush busy", 64'(bus.busy), 64'd0);
    cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) cnt++;
    end
    chk("flush no done", 64'(cnt), 64'd0);
    chk("flush hi", 64'(bus.hi), 64'(eh));
    chk("flush lo", 64'(bus.lo), 64'(el));

    launch(2'd3, 32'd100, 32'd7);
    bus.flush = 1'b1;
    wait_done(lat, bc);
    chk("flush+start latency", 64'(lat), 64'd33);
    chk("flush+start hi", 64'(bus.hi), 64'd2);
    chk("flush+start lo", 64'(bus.lo), 64'd14);

    launch(2'd0, 32'h7FFFFFFF, 32'h7FFFFFFF);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (11) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst busy", 64'(bus.busy), 64'd0);
    chk("rst done", 64'(bus.done), 64'd0);
    chk("rst hi", 64'(bus.hi), 64'd0);
    chk("rst lo", 64'(bus.lo), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done || bus.busy) cnt++;
    end
    chk("rst no done", 64'(cnt), 64'd0);

    do_op("post rst", 2'd2, 32'hFFFFFF9C, 32'd7);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
